// File: rtl/dmem_pkg.sv
// dmem_pkg: shared MMIO page constants, register decode and STATUS layout
package dmem_pkg;
  localparam logic [23:0] MMIO_PAGE = 24'hFFFFFF;
  localparam logic [7:0] OFF_CYCLES = 8'h00;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam int STAT_OVF = 7;
  localparam int STAT_CNT_HI = 3;
  localparam int STAT_CNT_LO = 0;
  typedef enum logic [1:0] {R_NONE, R_CYCLES, R_TXDATA, R_STATUS} mmio_reg_e;
  function automatic mmio_reg_e decode_reg(input logic [7:0] off);
    return off == OFF_CYCLES ? R_CYCLES :
           off == OFF_TXDATA ? R_TXDATA :
           off == OFF_STATUS ? R_STATUS : R_NONE;
  endfunction
endpackage

// File: rtl/dmem_mmio_responder_out_fifo.sv
// out_fifo: output queue with push acceptance that accounts for a same-cycle pop
module out_fifo #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [31:0]   data,
  input  logic          pop,
  output logic          push_ok,
  output logic [31:0]   head,
  output logic [CW-1:0] count
);
  logic [31:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic do_push;
  assign push_ok = count < CW'(DEPTH) || pop;
  assign do_push = push && push_ok;
  assign head = mem[rptr];
  // storage is never cleared; count gates validity
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= data;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + PW'(do_push);
      rptr <= rptr + PW'(pop);
      count <= count + CW'(do_push) - CW'(pop);
    end
endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: single-cycle data RAM plus MMIO page with cycle counter and output FIFO
module dmem_mmio_responder
  import dmem_pkg::*;
#(
  parameter int RAM_WORDS = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  input  logic        b,
  output logic [31:0] rd,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int IW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] mem [RAM_WORDS];
  logic [31:0] cycles, ram_word, mmio_word, word, status, cnt32;
  logic [IW-1:0] idx;
  logic [CW-1:0] count;
  logic is_mmio, ovf, push, push_ok, pop, stat_wr;
  mmio_reg_e sel;
  assign is_mmio = a[31:8] == MMIO_PAGE;
  assign sel = is_mmio ? decode_reg(a[7:0]) : R_NONE;
  assign idx = a[IW+1:2];
  assign ram_word = mem[idx];
  assign push = we && !reset && sel == R_TXDATA;
  assign stat_wr = we && !reset && sel == R_STATUS;
  assign pop = out_valid && out_ready;
  assign out_valid = count != '0;
  assign cnt32 = 32'(count);
  out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .data(wd), .pop(pop),
    .push_ok(push_ok), .head(out_data), .count(count)
  );
  // RAM stores are honoured even during reset
  always_ff @(posedge clk)
    if (we && !is_mmio) begin
      if (b) mem[idx][8*a[1:0] +: 8] <= wd[7:0];
      else mem[idx] <= wd;
    end
  // free-running cycle counter
  always_ff @(posedge clk)
    cycles <= reset ? '0 : cycles + 32'd1;
  // sticky overflow: a rejected push beats a clearing STATUS write
  always_ff @(posedge clk)
    if (reset) ovf <= 1'b0;
    else if (push && !push_ok) ovf <= 1'b1;
    else if (stat_wr) ovf <= 1'b0;
  // STATUS layout and MMIO/RAM read mux with byte-lane extraction
  always_comb begin
    status = '0;
    status[STAT_OVF] = ovf;
    status[STAT_CNT_HI:STAT_CNT_LO] = cnt32 > 32'd15 ? 4'hF : cnt32[3:0];
    mmio_word = sel == R_CYCLES ? cycles : sel == R_STATUS ? status : '0;
    word = is_mmio ? mmio_word : ram_word;
    rd = b ? {24'b0, word[8*a[1:0] +: 8]} : word;
  end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: table-driven RAM checks plus directed MMIO/FIFO sequences
module tb_dmem_mmio_responder;
  logic clk = 0, reset = 1, we = 0, b = 0, out_ready = 0, out_valid;
  logic [31:0] a = 0, wd = 0, rd, out_data;
  int n_chk = 0, n_fail = 0;
  localparam logic [31:0] CYC = 32'hFFFFFF00, TX = 32'hFFFFFF08, ST = 32'hFFFFFF0C;

  dmem_mmio_responder dut (
    .clk(clk), .reset(reset), .a(a), .wd(wd), .we(we), .b(b), .rd(rd),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we;
    logic b;
    logic [31:0] a;
    logic [31:0] wd;
    logic chk;
    logic [31:0] exp;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic bb, input logic [31:0] aa, input logic [31:0] d);
    we = w; b = bb; a = aa; wd = d;
    #2;
  endtask

  task automatic fill(input int n, input int base);
    out_ready = 0;
    for (int i = 0; i < n; i++) begin
      drive(1, 0, TX, 32'(base + i));
      step();
    end
    drive(0, 0, ST, 0);
  endtask

  task automatic drain(input string name, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    out_ready = 1;
    drive(0, 0, ST, 0);
    for (int i = 0; i < 4; i++) begin
      check({name, " valid"}, 32'(out_valid), 1);
      check({name, " data"}, out_data, e[i]);
      step();
    end
    out_ready = 0;
    #2;
    check({name, " empty"}, 32'(out_valid), 0);
  endtask

  vec_t vt [12];

  initial begin
    vt[0]  = '{1, 0, 32'h10, 32'hDEADBEEF, 0, 0};
    vt[1]  = '{1, 1, 32'h12, 32'h00000055, 0, 0};
    vt[2]  = '{0, 0, 32'h10, 0, 1, 32'hDE55BEEF};
    vt[3]  = '{0, 1, 32'h13, 0, 1, 32'h000000DE};
    vt[4]  = '{0, 1, 32'h10, 0, 1, 32'h000000EF};
    vt[5]  = '{0, 1, 32'h12, 0, 1, 32'h00000055};
    vt[6]  = '{0, 0, 32'h11, 0, 1, 32'hDE55BEEF};
    vt[7]  = '{0, 0, 32'hFFFFFF40, 0, 1, 32'h0};
    vt[8]  = '{1, 0, 32'h100, 32'h12345678, 0, 0};
    vt[9]  = '{0, 0, 32'h000, 0, 1, 32'h12345678};
    vt[10] = '{0, 0, TX, 0, 1, 32'h0};
    vt[11] = '{1, 0, 32'hFFFFFF40, 32'hFFFFFFFF, 0, 0};

    // reset held 3 cycles; STATUS reads 0 while reset is asserted
    drive(0, 0, ST, 0);
    repeat (3) step();
    check("status in reset", rd, 0);
    check("valid in reset", 32'(out_valid), 0);
    reset = 0;
    drive(0, 0, CYC, 0);
    repeat (5) step();
    check("cycles 5 after release", rd, 5);
    drive(0, 1, CYC, 0);
    check("cycles byte lane0", rd, 5);
    drive(0, 0, CYC, 0);
    force dut.cycles = 32'hFFFFFFFF;
    #1;
    check("cycles forced", rd, 32'hFFFFFFFF);
    release dut.cycles;
    step();
    #1;
    check("cycles wrap", rd, 0);

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].we, vt[i].b, vt[i].a, vt[i].wd);
      if (vt[i].chk) check($sformatf("vec%0d", i), rd, vt[i].exp);
      step();
    end
    drive(0, 0, 32'hFFFFFF40, 0);
    check("unmapped after write", rd, 0);

    // fill to capacity, then overflow
    fill(4, 1);
    check("status full", rd, 32'h04);
    check("head first", out_data, 1);
    drive(1, 0, TX, 5);
    step();
    drive(0, 0, ST, 0);
    check("status overflow", rd, 32'h84);
    drive(0, 1, ST, 0);
    check("status byte", rd, 32'h84);
    drive(0, 1, ST + 1, 0);
    check("status byte lane1", rd, 0);
    drain("drain1", 1, 2, 3, 4);
    drive(0, 0, ST, 0);
    check("status drained ovf", rd, 32'h80);
    drive(1, 1, ST, 0);
    step();
    drive(0, 0, ST, 0);
    check("status ovf cleared", rd, 0);

    // full with simultaneous push and pop
    fill(4, 1);
    out_ready = 1;
    drive(1, 0, TX, 9);
    step();
    out_ready = 0;
    drive(0, 0, ST, 0);
    check("status push+pop", rd, 32'h04);
    drain("drain2", 2, 3, 4, 9);

    // reset discards queued entries and suppresses the MMIO push
    fill(2, 20);
    check("two queued valid", 32'(out_valid), 1);
    check("status two", rd, 32'h02);
    reset = 1;
    drive(1, 0, TX, 7);
    step();
    reset = 0;
    drive(0, 0, ST, 0);
    check("valid after reset", 32'(out_valid), 0);
    check("status after reset", rd, 0);

    // RAM store during reset still lands
    reset = 1;
    drive(1, 0, 32'h20, 32'h0000ABCD);
    step();
    reset = 0;
    drive(0, 0, 32'h20, 0);
    check("ram write in reset", rd, 32'h0000ABCD);
    check("valid stays empty", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder end of the single-cycle core's data-memory interface. It answers the core's address, write-data, write-enable and byte-select signals, and returns read data in the same cycle.
- Holds a word-organised data RAM and a small MMIO page. The page contains a free-running cycle counter and an output FIFO; an external consumer drains the FIFO over a valid/ready handshake.
- Sits beside the instruction memory in the top level, wired to the core's ALU result (address), WriteData, MemWrite, B and ReadData.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; must be a power of two.
- FIFO_DEPTH, 4, number of output-FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- a  in  32  byte address from the core (ALU result).
- wd  in  32  store data from the core.
- we  in  1  store enable (the core's MemWrite).
- b  in  1  1 = byte access, 0 = word access.
- rd  out  32  load data; combinational in a, b and current state.
- out_data  out  32  head entry of the output FIFO.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data this cycle.

Behaviour:
- Decode: an address is MMIO when a[31:8] == 24'hFFFFFF; every other address is RAM.
  - RAM index = a[log2(RAM_WORDS)+1:2]; higher address bits are ignored (RAM aliases).
- RAM read is asynchronous.
  - Word read: rd = mem[idx], and a[1:0] is ignored.
  - Byte read: rd = zero-extended byte from lane a[1:0], little-endian (lane 0 = bits 7:0).
- RAM write is synchronous and happens when we=1 and the address is RAM.
  - Word write replaces the whole word.
  - Byte write updates only lane a[1:0] with wd[7:0]; the other lanes are unchanged.
  - RAM contents are not cleared by reset.
- MMIO map, by offset a[7:0]:
  - 0x00 CYCLES (R): 32-bit counter. Reset value 0; increments every cycle, including the cycle reset deasserts; wraps FFFFFFFF -> 0. Writes are ignored.
  - 0x08 TXDATA (W): a write pushes wd into the FIFO. Reads return 0.
  - 0x0C STATUS (R/W): read value {24'b0, overflow, 3'b0, count[3:0]}, where count saturates the field at 15. Any write clears overflow.
  - All other offsets read 0, and writes to them are ignored.
- MMIO byte access:
  - A byte read returns the selected lane of the register value.
  - On writes, b is ignored: a TXDATA write pushes all 32 bits of wd, and a STATUS write clears overflow.
- FIFO:
  - A pop occurs when out_valid && out_ready.
  - A push to TXDATA is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle (full with simultaneous push and pop: both happen, count unchanged).
  - A rejected push drops the data and sets the sticky overflow bit.
  - Overflow is set by a rejected push and cleared by a STATUS write. If both happen in the same cycle, set wins.
  - Count ranges from 0 to FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
  - out_data is the head entry; its value is don't-care when out_valid=0. out_valid is registered-state derived (count != 0), so a pushed word is visible on the next cycle.
- Reset values: CYCLES=0, count=0, overflow=0, read/write pointers=0, out_valid=0.
  - rd follows decode immediately, e.g. a STATUS read reads 0 while reset is held.
- Reset mid-operation: FIFO contents are discarded, and a write presented in the reset cycle has no MMIO effect. A RAM write in the reset cycle is still performed.
- No wait states: every access completes in one cycle, matching the single-cycle core.

Decomposition:
- Shared package dmem_pkg holds:
  - MMIO_PAGE (24'hFFFFFF);
  - offsets OFF_CYCLES, OFF_TXDATA, OFF_STATUS;
  - the STATUS bit positions (overflow bit 7, count bits 3:0).
- One sub-module: out_fifo. It contains the FIFO_DEPTH x 32 storage, the pointers and the count, and exposes push, push_ok, pop, head, count.
- Address decode, RAM, CYCLES and the read mux live in the top block.

Test Plan:
- Word store 0xDEADBEEF to 0x10, then byte store 0x55 to 0x12 -> word read of 0x10 = 0xDE55BEEF; byte read of 0x13 = 0x000000DE.
- Reset held 3 cycles, then released -> CYCLES read 5 cycles after release = 5. Preload CYCLES via force to FFFFFFFF, advance one cycle -> reads 0.
- Push 1,2,3,4 to 0xFFFFFF08 with out_ready=0 -> STATUS = 0x04. A fifth push 5 -> STATUS = 0x84 and the data is dropped. Drain with out_ready=1 -> out_data sequence 1,2,3,4, then out_valid=0.
- FIFO full, push 9 with out_ready=1 in the same cycle -> pop of 1 and push of 9 both occur; STATUS count stays 4, overflow stays 0; the drain order ends ...,4,9.
- Overflow set, then store to 0xFFFFFF0C -> STATUS bit 7 clears. Reset asserted with 2 entries queued -> out_valid=0 and STATUS=0 the next cycle.
- Word read of an unmapped MMIO offset 0xFFFFFF40 = 0. Word store 0x12345678 to 0x100 with RAM_WORDS=64 -> word read of 0x000 returns 0x12345678 (aliasing).
